// File: rtl/boot_loader_if.sv
// -----------------------------------------------------------------------------
// boot_loader_if
// Byte-stream and memory-write signals of the program loader, bundled so the
// loader and its environment (host link plus CPU memory) connect through a
// single port.
//
// Signals:
//   i_RXDATA   [7:0]  incoming byte from the host link
//   i_RXVALID         i_RXDATA is valid
//   o_RXREADY         loader accepts a byte (transfer = valid && ready)
//   o_MEMWADDR [15:0] memory word address of the pending write
//   o_MEMWDATA [15:0] memory word data of the pending write
//   f_MEMWRITE        write request, held until accepted
//   i_MEMREADY        memory accepts the pending write this cycle
//
// Modports:
//   slave  : the loader itself (consumes the byte stream, issues writes)
//   master : the environment (supplies bytes, accepts writes)
// -----------------------------------------------------------------------------
interface boot_loader_if;
  logic [7:0]  i_RXDATA;
  logic        i_RXVALID;
  logic        o_RXREADY;
  logic [15:0] o_MEMWADDR;
  logic [15:0] o_MEMWDATA;
  logic        f_MEMWRITE;
  logic        i_MEMREADY;

  modport slave (
    input  i_RXDATA,
    input  i_RXVALID,
    input  i_MEMREADY,
    output o_RXREADY,
    output o_MEMWADDR,
    output o_MEMWDATA,
    output f_MEMWRITE
  );

  modport master (
    output i_RXDATA,
    output i_RXVALID,
    output i_MEMREADY,
    input  o_RXREADY,
    input  o_MEMWADDR,
    input  o_MEMWDATA,
    input  f_MEMWRITE
  );
endinterface

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Upstream program loader for the stack CPU. Receives a framed byte stream
//   SYNC_BYTE, LEN_HI, LEN_LO, 2*N data bytes (big-endian words), CHK
// where CHK is the 8-bit sum of LEN_HI, LEN_LO and all data bytes. Each word
// is written to CPU memory at LOAD_BASE + index (wrapping mod 2^16). The CPU
// clock divisor is held paused until a frame with a matching checksum has been
// completely written; after that the loader sits in DONE until reset.
//
// Parameters:
//   LOAD_BASE  word address of the first loaded word
//   SYNC_BYTE  frame start marker
//   TIMEOUT    idle cycles allowed mid-frame before abort (0 disables)
//
// Ports:
//   i_CLOCK    system clock (same clock as the CPU clock divisor)
//   i_RESET    synchronous active-high reset
//   bus        byte stream in / memory write out (boot_loader_if.slave)
//   o_CPUHOLD  divisor pause; high while the CPU must stay frozen
//   o_DONE     load complete, CPU running
//   o_ERROR    sticky: last frame aborted (bad checksum or timeout)
//
// Every output comes straight from a flop; output flops are loaded from the
// decoded next state so they line up with the state register.
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1024
) (
  input  logic         i_CLOCK,
  input  logic         i_RESET,
  boot_loader_if.slave bus,
  output logic         o_CPUHOLD,
  output logic         o_DONE,
  output logic         o_ERROR
);

  // Counter only has to hold values 0 .. TIMEOUT-1.
  localparam int TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [TW-1:0] TMO_LAST = TMO_LAST_INT[TW-1:0];

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Running frame checksum: plain 8-bit modular sum.
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    lo_q, lo_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;

  logic          rxready_q, rxready_d;
  logic          memwrite_q, memwrite_d;
  logic          cpuhold_q, cpuhold_d;
  logic          done_q, done_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;

  logic          accept_s;
  logic          timed_s;
  logic          tmo_hit_s;

  // o_RXREADY is a flop, so the handshake itself has no path from i_RXVALID
  // to any output.
  assign accept_s  = bus.i_RXVALID && rxready_q;
  assign tmo_hit_s = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // States in which the idle timer runs; WRITE is excluded so memory
  // backpressure never counts as host inactivity.
  always_comb begin
    timed_s = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: timed_s = 1'b1;
      default:                                           timed_s = 1'b0;
    endcase
  end

  // Next-state and datapath: frame parsing, checksum, word index and aborts.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    error_d = error_q;
    case (state_q)
      S_SYNC: begin
        if (accept_s && (bus.i_RXDATA == SYNC_BYTE)) begin
          state_d = S_LEN_HI;
          error_d = 1'b0;
          sum_d   = 8'h00;
          idx_d   = 16'h0000;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          len_d[15:8] = bus.i_RXDATA;
          sum_d       = chk_add(sum_q, bus.i_RXDATA);
          state_d     = S_LEN_LO;
        end else if (tmo_hit_s) begin
          error_d = 1'b1;
          state_d = S_SYNC;
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_d[7:0] = bus.i_RXDATA;
          sum_d      = chk_add(sum_q, bus.i_RXDATA);
          // An empty frame skips straight to the checksum byte.
          if ({len_q[15:8], bus.i_RXDATA} == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end else if (tmo_hit_s) begin
          error_d = 1'b1;
          state_d = S_SYNC;
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA_HI: begin
        if (accept_s) begin
          hi_d    = bus.i_RXDATA;
          sum_d   = chk_add(sum_q, bus.i_RXDATA);
          state_d = S_DATA_LO;
        end else if (tmo_hit_s) begin
          error_d = 1'b1;
          state_d = S_SYNC;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_LO: begin
        if (accept_s) begin
          lo_d    = bus.i_RXDATA;
          sum_d   = chk_add(sum_q, bus.i_RXDATA);
          state_d = S_WRITE;
        end else if (tmo_hit_s) begin
          error_d = 1'b1;
          state_d = S_SYNC;
        end else begin
          state_d = S_DATA_LO;
        end
      end
      S_WRITE: begin
        if (bus.i_MEMREADY) begin
          idx_d = idx_q + 16'd1;
          // 16-bit compare: N=65535 ends after index 65534 is written.
          if ((idx_q + 16'd1) == len_q) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_CHECK: begin
        if (accept_s) begin
          if (bus.i_RXDATA == sum_q) begin
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_SYNC;
          end
        end else if (tmo_hit_s) begin
          error_d = 1'b1;
          state_d = S_SYNC;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  // Idle timer: restarts on every accepted byte and every state change,
  // counts in the timed states, otherwise holds.
  always_comb begin
    if (accept_s || (state_d != state_q)) begin
      tmo_d = '0;
    end else if (timed_s && (TIMEOUT != 0)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Output decode from the next state, so the output flops track state_q.
  always_comb begin
    rxready_d  = 1'b0;
    memwrite_d = 1'b0;
    cpuhold_d  = 1'b1;
    done_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_d)
      S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
        rxready_d = 1'b1;
      end
      S_WRITE: begin
        memwrite_d = 1'b1;
      end
      S_DONE: begin
        cpuhold_d = 1'b0;
        done_d    = 1'b1;
      end
      default: begin
        rxready_d = 1'b0;
      end
    endcase
    // Address/data load only on entry to WRITE so they stay put while the
    // memory stalls the request.
    if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
      addr_d = LOAD_BASE + idx_q;
      data_d = {hi_d, lo_d};
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q    <= S_SYNC;
      len_q      <= 16'h0000;
      hi_q       <= 8'h00;
      lo_q       <= 8'h00;
      idx_q      <= 16'h0000;
      sum_q      <= 8'h00;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      rxready_q  <= 1'b1;
      memwrite_q <= 1'b0;
      cpuhold_q  <= 1'b1;
      done_q     <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      rxready_q  <= rxready_d;
      memwrite_q <= memwrite_d;
      cpuhold_q  <= cpuhold_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.o_RXREADY  = rxready_q;
  assign bus.f_MEMWRITE = memwrite_q;
  assign bus.o_MEMWADDR = addr_q;
  assign bus.o_MEMWDATA = data_q;
  assign o_CPUHOLD      = cpuhold_q;
  assign o_DONE         = done_q;
  assign o_ERROR        = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Self-checking bench for boot_loader. Frames are built from random payloads;
// the expected write list (LOAD_BASE + i, {hi,lo}) and the frame outcome
// (checksum = byte sum mod 256) are computed directly from the frame bytes.
// A monitor drives random memory backpressure, records accepted writes and
// checks that a stalled write holds address/data.
// -----------------------------------------------------------------------------
module tb_boot_loader;
  localparam logic [15:0] BASE = 16'hFFFF;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int          TMO  = 16;

  localparam int R_GARB = 0;
  localparam int R_SYNC = 1;
  localparam int R_LEN  = 2;
  localparam int R_DHI  = 3;
  localparam int R_DLO  = 4;
  localparam int R_OK   = 5;
  localparam int R_BAD  = 6;

  logic clk = 1'b0;
  logic rst;
  logic cpuhold, done, error;

  boot_loader_if bif();

  boot_loader #(.LOAD_BASE(BASE), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
    .i_CLOCK  (clk),
    .i_RESET  (rst),
    .bus      (bif),
    .o_CPUHOLD(cpuhold),
    .o_DONE   (done),
    .o_ERROR  (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory-side monitor ----------------
  logic [31:0] obs_q[$];   // {addr, data} of each accepted write
  int          wlen_q[$];  // cycles f_MEMWRITE was high for each write
  int          run = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] addr_prev, data_prev;
  logic        mr;
  bit          force_low = 1'b0;
  int          bp_left = 0;
  bit          bp_go = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      run = 0;
      stall_prev = 1'b0;
      bif.i_MEMREADY = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_hold", 32'(bif.f_MEMWRITE), 32'd1);
        check_eq("stall_addr", 32'(bif.o_MEMWADDR), 32'(addr_prev));
        check_eq("stall_data", 32'(bif.o_MEMWDATA), 32'(data_prev));
      end
      if (bif.f_MEMWRITE) begin
        check_eq("busy_rdy", 32'(bif.o_RXREADY), 32'd0);
        run++;
        if (force_low) begin
          mr = 1'b0;
        end else if (bp_left > 0) begin
          mr = 1'b0;
          bp_left--;
          if (bp_left == 0) bp_go = 1'b1;
        end else if (bp_go) begin
          mr = 1'b1;
          bp_go = 1'b0;
        end else begin
          mr = 1'($urandom_range(0, 1));
        end
        if (mr) begin
          obs_q.push_back({bif.o_MEMWADDR, bif.o_MEMWDATA});
          wlen_q.push_back(run);
          run = 0;
        end
        stall_prev = !mr;
        addr_prev = bif.o_MEMWADDR;
        data_prev = bif.o_MEMWDATA;
      end else begin
        mr = 1'($urandom_range(0, 1));
        stall_prev = 1'b0;
      end
      bif.i_MEMREADY = mr;
    end
  end

  // ---------------- reference model helpers ----------------
  logic [7:0] pay[$];   // payload bytes of the frame being sent (2*N)

  function automatic logic [7:0] frame_sum();
    int n;
    int acc;
    n = pay.size() / 2;
    acc = (n / 256) + (n % 256);
    foreach (pay[i]) acc += int'(pay[i]);
    return acc[7:0];
  endfunction

  task automatic rand_payload(input int n);
    pay.delete();
    for (int i = 0; i < 2 * n; i++) pay.push_back(8'($urandom));
  endtask

  // ---------------- driver ----------------
  // Starts and ends on a falling edge; checks the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b, input int role);
    int budget;
    repeat (int'($urandom_range(0, 2))) @(negedge clk);
    bif.i_RXVALID = 1'b1;
    bif.i_RXDATA  = b;
    budget = 0;
    while (bif.o_RXREADY !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (bif.o_RXREADY !== 1'b1) begin
      check_eq("rx_wait", 32'(bif.o_RXREADY), 32'd1);
      bif.i_RXVALID = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bif.i_RXVALID = 1'b0;
    bif.i_RXDATA  = 8'($urandom);
    case (role)
      R_SYNC: begin
        check_eq("sync_err", 32'(error), 32'd0);
        check_eq("sync_rdy", 32'(bif.o_RXREADY), 32'd1);
        check_eq("sync_hold", 32'(cpuhold), 32'd1);
      end
      R_DLO: begin
        check_eq("dlo_wr", 32'(bif.f_MEMWRITE), 32'd1);
        check_eq("dlo_rdy", 32'(bif.o_RXREADY), 32'd0);
      end
      R_OK: begin
        check_eq("ok_done", 32'(done), 32'd1);
        check_eq("ok_hold", 32'(cpuhold), 32'd0);
        check_eq("ok_err", 32'(error), 32'd0);
        check_eq("ok_rdy", 32'(bif.o_RXREADY), 32'd0);
      end
      R_BAD: begin
        check_eq("bad_err", 32'(error), 32'd1);
        check_eq("bad_hold", 32'(cpuhold), 32'd1);
        check_eq("bad_done", 32'(done), 32'd0);
        check_eq("bad_rdy", 32'(bif.o_RXREADY), 32'd1);
      end
      default: begin
        check_eq("mid_hold", 32'(cpuhold), 32'd1);
        check_eq("mid_done", 32'(done), 32'd0);
      end
    endcase
  endtask

  // Sends SYNC, length, payload and chk, then compares the written words.
  task automatic send_frame(input logic [7:0] chk);
    int n;
    logic [15:0] ea;
    logic [15:0] ed;
    n = pay.size() / 2;
    obs_q.delete();
    wlen_q.delete();
    send_byte(SYNC, R_SYNC);
    send_byte(n[15:8], R_LEN);
    send_byte(n[7:0], R_LEN);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[2*i], R_DHI);
      send_byte(pay[2*i+1], R_DLO);
    end
    send_byte(chk, (chk == frame_sum()) ? R_OK : R_BAD);
    check_eq("wr_count", 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      ea = BASE + 16'(i);
      ed = {pay[2*i], pay[2*i+1]};
      check_eq("wr_addr", 32'(obs_q[i][31:16]), 32'(ea));
      check_eq("wr_data", 32'(obs_q[i][15:0]), 32'(ed));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rdy"},  32'(bif.o_RXREADY),  32'd1);
    check_eq({tag, "_hold"}, 32'(cpuhold),        32'd1);
    check_eq({tag, "_done"}, 32'(done),           32'd0);
    check_eq({tag, "_err"},  32'(error),          32'd0);
    check_eq({tag, "_wr"},   32'(bif.f_MEMWRITE), 32'd0);
    check_eq({tag, "_addr"}, 32'(bif.o_MEMWADDR), 32'd0);
    check_eq({tag, "_data"}, 32'(bif.o_MEMWDATA), 32'd0);
  endtask

  // One-cycle reset pulse, starting and ending on a falling edge.
  task automatic do_reset();
    bif.i_RXVALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    wlen_q.delete();
  endtask

  task automatic nominal_payload();
    pay.delete();
    pay.push_back(8'h12); pay.push_back(8'h34);
    pay.push_back(8'hAB); pay.push_back(8'hCD);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] s;
    rst = 1'b1;
    bif.i_RXVALID = 1'b0;
    bif.i_RXDATA  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst0");

    // Nominal load; base FFFF so the second word wraps to address 0000.
    nominal_payload();
    send_frame(8'hC0);
    bif.i_RXVALID = 1'b1;
    bif.i_RXDATA  = SYNC;
    repeat (4) @(negedge clk);
    bif.i_RXVALID = 1'b0;
    check_eq("done_stuck", 32'(done), 32'd1);
    check_eq("done_rdy", 32'(bif.o_RXREADY), 32'd0);
    check_eq("done_wr", 32'(bif.f_MEMWRITE), 32'd0);

    // Bad checksum, then a good resend.
    do_reset();
    check_reset_state("rst1");
    nominal_payload();
    send_frame(8'hC1);
    send_frame(8'hC0);

    // Garbage bytes, empty frame with wrong then right checksum.
    do_reset();
    send_byte(8'h00, R_GARB);
    send_byte(8'hFF, R_GARB);
    pay.delete();
    send_frame(8'h02);
    send_frame(8'h00);

    // Long memory stall on the first write: 20 stalled cycles (> TMO).
    do_reset();
    rand_payload(2);
    bp_left = 20;
    bp_go = 1'b0;
    send_frame(frame_sum());
    check_eq("bp_used", 32'(bp_left), 32'd0);
    if (wlen_q.size() > 0) check_eq("bp_len", 32'(wlen_q[0]), 32'd21);
    else check_eq("bp_nowr", 32'(wlen_q.size()), 32'd1);

    // Timeout: A5 00 then silence; abort exactly TMO cycles into LEN_LO.
    do_reset();
    send_byte(SYNC, R_SYNC);
    send_byte(8'h00, R_LEN);
    repeat (TMO - 1) @(negedge clk);
    check_eq("tmo_early_err", 32'(error), 32'd0);
    @(negedge clk);
    check_eq("tmo_err", 32'(error), 32'd1);
    check_eq("tmo_hold", 32'(cpuhold), 32'd1);
    check_eq("tmo_rdy", 32'(bif.o_RXREADY), 32'd1);
    rand_payload(2);
    send_frame(frame_sum());

    // Random frames, some with a corrupted checksum followed by a resend.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      rand_payload(int'($urandom_range(0, 5)));
      s = frame_sum();
      if ($urandom_range(0, 1) == 1) send_frame(s + 8'($urandom_range(1, 255)));
      send_frame(s);
    end

    // Reset while a write is stalled: write dropped, loader clean.
    do_reset();
    nominal_payload();
    force_low = 1'b1;
    send_byte(SYNC, R_SYNC);
    send_byte(8'h00, R_LEN);
    send_byte(8'h02, R_LEN);
    send_byte(8'h12, R_DHI);
    send_byte(8'h34, R_DLO);
    repeat (2) @(negedge clk);
    check_eq("rw_pending", 32'(bif.f_MEMWRITE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_low = 1'b0;
    check_eq("rw_wr", 32'(bif.f_MEMWRITE), 32'd0);
    check_eq("rw_rdy", 32'(bif.o_RXREADY), 32'd1);
    check_eq("rw_hold", 32'(cpuhold), 32'd1);
    check_eq("rw_done", 32'(done), 32'd0);
    check_eq("rw_err", 32'(error), 32'd0);
    check_eq("rw_nowr", 32'(obs_q.size()), 32'd0);
    send_frame(8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
